// File: rtl/i2c_touch_target.sv
// rtl/i2c_touch_target.sv - I2C target emulating an FT6206-class multi-touch controller
module i2c_touch_target #(
  parameter logic [6:0] ADDR        = 7'h38,
  parameter int         NUM_TOUCHES = 2,
  parameter logic [7:0] VENDOR_ID   = 8'h11,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scl,
  input  logic                      sda_in,
  output logic                      sda_oe,
  input  logic [NUM_TOUCHES-1:0]    touch_valid,
  input  logic [12*NUM_TOUCHES-1:0] touch_x,
  input  logic [12*NUM_TOUCHES-1:0] touch_y,
  output logic                      irq_b,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0]    r_scl_sync, r_sda_sync;
  logic                      r_scl_d, r_sda_d;
  logic                      w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  state_t                    r_state, w_state_nxt;
  logic [7:0]                r_shift, w_shift_nxt;
  logic [3:0]                r_bit_cnt, w_bit_cnt_nxt;
  logic                      r_rw, w_rw_nxt;
  logic [7:0]                r_ptr, w_ptr_nxt;
  logic                      r_ptr_set, w_ptr_set_nxt;
  logic [7:0]                r_tx, w_tx_nxt;
  logic                      r_mack, w_mack_nxt;
  logic                      r_sda_oe, w_sda_oe_nxt;
  logic                      r_busy, r_irq_b;
  logic [NUM_TOUCHES-1:0]    r_snap_v;
  logic [12*NUM_TOUCHES-1:0] r_snap_x, r_snap_y;
  logic [7:0]                w_rd_cur, w_rd_next;

  // Register map decode over the transaction snapshot; invalid slots report event 2'b11 with zeroed X/Y.
  function automatic logic [7:0] f_reg(input logic [7:0] a,
                                       input logic [NUM_TOUCHES-1:0] v,
                                       input logic [12*NUM_TOUCHES-1:0] x,
                                       input logic [12*NUM_TOUCHES-1:0] y);
    logic [7:0]  d;
    logic [7:0]  base;
    logic [11:0] xs, ys;
    d = 8'h00;
    if (a == 8'h02) begin
      for (int k = 0; k < NUM_TOUCHES; k++) d = d + 8'(v[k]);
    end else if (a == 8'hA8) begin
      d = VENDOR_ID;
    end
    for (int k = 0; k < NUM_TOUCHES; k++) begin
      base = 8'(3 + 6 * k);
      xs   = v[k] ? x[12*k +: 12] : 12'h000;
      ys   = v[k] ? y[12*k +: 12] : 12'h000;
      if (a == base)               d = {(v[k] ? 2'b10 : 2'b11), 2'b00, xs[11:8]};
      else if (a == base + 8'd1)   d = xs[7:0];
      else if (a == base + 8'd2)   d = {4'(k), ys[11:8]};
      else if (a == base + 8'd3)   d = ys[7:0];
    end
    return d;
  endfunction

  assign w_rd_cur  = f_reg(r_ptr, r_snap_v, r_snap_x, r_snap_y);
  assign w_rd_next = f_reg(r_ptr + 8'd1, r_snap_v, r_snap_x, r_snap_y);

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign sda_oe = r_sda_oe;
  assign irq_b  = r_irq_b;
  assign busy   = r_busy;

  // Bus synchronizers plus one-flop history for edge and START/STOP detection; idle bus is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  // Protocol state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 4'd0;
      r_rw      <= 1'b0;
      r_ptr     <= 8'h00;
      r_ptr_set <= 1'b0;
      r_tx      <= 8'h00;
      r_mack    <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_rw      <= w_rw_nxt;
      r_ptr     <= w_ptr_nxt;
      r_ptr_set <= w_ptr_set_nxt;
      r_tx      <= w_tx_nxt;
      r_mack    <= w_mack_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
    end
  end

  // Touch snapshot on every (repeated) START, busy flag, and interrupt straight from the live inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_v <= '0;
      r_snap_x <= '0;
      r_snap_y <= '0;
      r_busy   <= 1'b0;
      r_irq_b  <= 1'b1;
    end else begin
      if (w_start) begin
        r_snap_v <= touch_valid;
        r_snap_x <= touch_x;
        r_snap_y <= touch_y;
        r_busy   <= 1'b1;
      end else if (w_stop) begin
        r_busy   <= 1'b0;
      end
      r_irq_b <= ~(|touch_valid);
    end
  end

  // Next-state logic; SDA drive only changes on an SCL fall so it holds past the rising edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rw_nxt      = r_rw;
    w_ptr_nxt     = r_ptr;
    w_ptr_set_nxt = r_ptr_set;
    w_tx_nxt      = r_tx;
    w_mack_nxt    = r_mack;
    w_sda_oe_nxt  = r_sda_oe;
    case (r_state)
      S_ADDR, S_WR_BYTE: begin
        if (w_scl_rise) begin
          w_shift_nxt   = {r_shift[6:0], w_sda};
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
          if (r_state == S_ADDR) begin
            if (r_shift[7:1] == ADDR) begin
              w_state_nxt  = S_ADDR_ACK;
              w_sda_oe_nxt = 1'b1;
              w_rw_nxt     = r_shift[0];
            end else begin
              w_state_nxt  = S_WAIT_STOP;
            end
          end else begin
            w_state_nxt   = S_WR_ACK;
            w_sda_oe_nxt  = 1'b1;
            w_ptr_set_nxt = 1'b1;
            w_ptr_nxt     = r_ptr_set ? r_ptr + 8'd1 : r_shift;
          end
        end
      end
      S_ADDR_ACK: begin
        if (w_scl_fall) begin
          if (r_rw) begin
            w_state_nxt   = S_RD_BYTE;
            w_sda_oe_nxt  = ~w_rd_cur[7];
            w_tx_nxt      = {w_rd_cur[6:0], 1'b0};
            w_bit_cnt_nxt = 4'd1;
          end else begin
            w_state_nxt   = S_WR_BYTE;
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
          end
        end
      end
      S_WR_ACK: begin
        if (w_scl_fall) begin
          w_state_nxt   = S_WR_BYTE;
          w_sda_oe_nxt  = 1'b0;
          w_bit_cnt_nxt = 4'd0;
        end
      end
      S_RD_BYTE: begin
        if (w_scl_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_state_nxt  = S_RD_ACK;
            w_sda_oe_nxt = 1'b0;
            w_mack_nxt   = 1'b0;
          end else begin
            w_sda_oe_nxt  = ~r_tx[7];
            w_tx_nxt      = {r_tx[6:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      S_RD_ACK: begin
        if (w_scl_rise) begin
          if (!w_sda) begin
            w_ptr_nxt  = r_ptr + 8'd1;
            w_tx_nxt   = w_rd_next;
            w_mack_nxt = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_STOP;
          end
        end else if (w_scl_fall && r_mack) begin
          w_state_nxt   = S_RD_BYTE;
          w_sda_oe_nxt  = ~r_tx[7];
          w_tx_nxt      = {r_tx[6:0], 1'b0};
          w_bit_cnt_nxt = 4'd1;
        end
      end
      default: ;
    endcase
    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_sda_oe_nxt  = 1'b0;
      w_bit_cnt_nxt = 4'd0;
      w_ptr_set_nxt = 1'b0;
    end
  end

endmodule
